// File: rtl/seq_controller_if.sv
// Handshake bundle between the SEQ stage sequencer and the surrounding
// datapath. The slave side is the sequencer, the master side the
// datapath blocks and data memory that feed it.
interface seq_controller_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [3:0]       icode;
  logic             imem_error;
  logic             instr_valid;
  logic             mem_ready;
  logic             dmem_error;

  logic             fetch_en;
  logic             decode_en;
  logic             execute_en;
  logic             memory_en;
  logic             wb_en;
  logic             pc_en;
  logic             mem_req;
  logic             busy;
  logic             instr_done;
  logic [2:0]       stat;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, icode, imem_error, instr_valid, mem_ready, dmem_error,
    input  fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en,
           mem_req, busy, instr_done, stat, cycle_count, instr_count
  );

  modport slave (
    input  start, icode, imem_error, instr_valid, mem_ready, dmem_error,
    output fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en,
           mem_req, busy, instr_done, stat, cycle_count, instr_count
  );
endinterface

// File: rtl/seq_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath. Walks each
// instruction through F/D/E/M/W/PC-update with one stage enable per cycle,
// stalls MEMORY on the data-memory handshake (with a timeout), and tracks
// processor status plus cycle/retire counters.
module seq_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic            clk,
  input logic            rst,
  seq_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           state_n;
  stat_t            stat_q;
  stat_t            stat_n;
  logic [3:0]       icode_q;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  logic fetch_q;
  logic decode_q;
  logic execute_q;
  logic memory_q;
  logic wb_q;
  logic pc_q;
  logic mem_req_q;
  logic busy_q;
  logic done_q;

  logic mem_access;
  logic timeout_hit;
  logic enter_memory;

  // Instructions that touch data memory, judged on the latched icode.
  always_comb begin
    mem_access = 1'b0;
    case (icode_q)
      IC_RMMOVQ, IC_MRMOVQ, IC_CALL, IC_RET, IC_PUSHQ, IC_POPQ: mem_access = 1'b1;
      default:                                                  mem_access = 1'b0;
    endcase
  end

  // Timeout fires on the last allowed wait cycle; ready on that cycle wins
  // because the ready branch is checked first in the next-state logic.
  always_comb begin
    timeout_hit  = (wait_cnt == WAIT_LAST);
    enter_memory = (state_n == S_MEMORY) && (state != S_MEMORY);
  end

  // Next-state and next-status selection.
  always_comb begin
    state_n = state;
    stat_n  = stat_q;
    case (state)
      S_IDLE: begin
        if (bus.start) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_error) begin
          state_n = S_HALTED;
          stat_n  = STAT_ADR;
        end else if (!bus.instr_valid) begin
          state_n = S_HALTED;
          stat_n  = STAT_INS;
        end else if (bus.icode == IC_HALT) begin
          state_n = S_HALTED;
          stat_n  = STAT_HLT;
        end else begin
          state_n = S_DECODE;
        end
      end
      S_DECODE:  state_n = S_EXECUTE;
      S_EXECUTE: state_n = S_MEMORY;
      S_MEMORY: begin
        if (!mem_access) begin
          state_n = S_WRITEBACK;
        end else if (bus.mem_ready) begin
          if (bus.dmem_error) begin
            state_n = S_HALTED;
            stat_n  = STAT_ADR;
          end else begin
            state_n = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_n = S_HALTED;
          stat_n  = STAT_ADR;
        end
      end
      S_WRITEBACK: state_n = S_PCUPD;
      S_PCUPD:     state_n = S_FETCH;
      S_HALTED:    state_n = S_HALTED;
      default:     state_n = S_IDLE;
    endcase
  end

  // State, status, counters and Moore outputs registered together; outputs
  // are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      stat_q    <= STAT_AOK;
      icode_q   <= '0;
      wait_cnt  <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      fetch_q   <= 1'b0;
      decode_q  <= 1'b0;
      execute_q <= 1'b0;
      memory_q  <= 1'b0;
      wb_q      <= 1'b0;
      pc_q      <= 1'b0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_n;
      stat_q <= stat_n;

      if (state == S_FETCH) icode_q <= bus.icode;

      if (enter_memory) begin
        wait_cnt <= '0;
      end else if (state == S_MEMORY && mem_access && !bus.mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (busy_q) cycle_cnt <= cycle_cnt + 1'b1;
      if (state == S_PCUPD) instr_cnt <= instr_cnt + 1'b1;

      fetch_q   <= (state_n == S_FETCH);
      decode_q  <= (state_n == S_DECODE);
      execute_q <= (state_n == S_EXECUTE);
      memory_q  <= (state_n == S_MEMORY);
      wb_q      <= (state_n == S_WRITEBACK);
      pc_q      <= (state_n == S_PCUPD);
      // icode_q is already stable when MEMORY is entered from EXECUTE.
      mem_req_q <= (state_n == S_MEMORY) && mem_access;
      busy_q    <= (state_n != S_IDLE) && (state_n != S_HALTED);
      done_q    <= (state_n == S_PCUPD);
    end
  end

  assign bus.fetch_en    = fetch_q;
  assign bus.decode_en   = decode_q;
  assign bus.execute_en  = execute_q;
  assign bus.memory_en   = memory_q;
  assign bus.wb_en       = wb_q;
  assign bus.pc_en       = pc_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.busy        = busy_q;
  assign bus.instr_done  = done_q;
  assign bus.stat        = stat_q;
  assign bus.cycle_count = cycle_cnt;
  assign bus.instr_count = instr_cnt;

endmodule

// File: tb/tb_seq_controller.sv
// Directed-plus-random bench for seq_controller. A per-instruction model
// derives the expected stage trace, status and counters from the
// instruction rules and checks every cycle.
module tb_seq_controller;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // {fetch, decode, execute, memory, wb, pc, mem_req, busy, instr_done}
  localparam logic [8:0] O_IDLE = 9'b000000_000;
  localparam logic [8:0] O_F    = 9'b100000_010;
  localparam logic [8:0] O_D    = 9'b010000_010;
  localparam logic [8:0] O_E    = 9'b001000_010;
  localparam logic [8:0] O_M    = 9'b000100_010;
  localparam logic [8:0] O_MR   = 9'b000100_110;
  localparam logic [8:0] O_W    = 9'b000010_010;
  localparam logic [8:0] O_P    = 9'b000001_011;
  localparam logic [8:0] O_H    = 9'b000000_000;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_controller_if #(.CNT_W(CNT_W)) bus ();

  seq_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int mreq_seen;
  int done_seen;
  bit halted;

  logic [CNT_W-1:0] exp_cyc;
  logic [CNT_W-1:0] exp_ins;
  logic [2:0]       exp_stat;

  function automatic logic rnd1();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic bit is_mem(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  function automatic logic [8:0] outs();
    return {bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en,
            bus.wb_en, bus.pc_en, bus.mem_req, bus.busy, bus.instr_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle, drive inputs for the next edge, then advance.
  task automatic step(input logic [8:0] exp, input logic st, input logic [3:0] ic,
                      input logic imem, input logic iv, input logic rdy,
                      input logic derr, input logic r);
    check("outputs", 32'(outs()), 32'(exp));
    check("stat", 32'(bus.stat), 32'(exp_stat));
    check("cycle_count", 32'(bus.cycle_count), 32'(exp_cyc));
    check("instr_count", 32'(bus.instr_count), 32'(exp_ins));
    if (bus.mem_req === 1'b1) mreq_seen++;
    if (bus.instr_done === 1'b1) done_seen++;
    bus.start       = st;
    bus.icode       = ic;
    bus.imem_error  = imem;
    bus.instr_valid = iv;
    bus.mem_ready   = rdy;
    bus.dmem_error  = derr;
    rst             = r;
    @(negedge clk);
    if (r) begin
      exp_cyc  = '0;
      exp_ins  = '0;
      exp_stat = AOK;
    end else begin
      if (exp[1]) exp_cyc = exp_cyc + 1'b1;
      if (exp[0]) exp_ins = exp_ins + 1'b1;
    end
  endtask

  task automatic junk(input logic [8:0] exp);
    step(exp, rnd1(), rnd4(), rnd1(), rnd1(), rnd1(), rnd1(), 1'b0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    exp_cyc  = '0;
    exp_ins  = '0;
    exp_stat = AOK;
  endtask

  task automatic idle_start();
    step(O_IDLE, 1'b1, rnd4(), rnd1(), rnd1(), rnd1(), rnd1(), 1'b0);
  endtask

  // One instruction from its FETCH cycle. delay = cycles mem_ready stays
  // low after mem_req rises; a value >= MEM_TIMEOUT (or negative) never acks.
  task automatic run_instr(input logic [3:0] ic, input logic imem, input logic iv,
                           input int delay, input logic derr);
    logic rdy;
    halted = 1'b0;
    step(O_F, rnd1(), ic, imem, iv, rnd1(), rnd1(), 1'b0);
    if (imem) begin exp_stat = ADR; halted = 1'b1; return; end
    if (!iv)  begin exp_stat = INS; halted = 1'b1; return; end
    if (ic == 4'h0) begin exp_stat = HLT; halted = 1'b1; return; end
    junk(O_D);
    junk(O_E);
    if (is_mem(ic)) begin
      for (int k = 0; k < MEM_TIMEOUT; k++) begin
        rdy = (k == delay);
        step(O_MR, rnd1(), rnd4(), rnd1(), rnd1(), rdy, rdy ? derr : rnd1(), 1'b0);
        if (rdy) begin
          if (derr) begin exp_stat = ADR; halted = 1'b1; return; end
          break;
        end
        if (k == MEM_TIMEOUT - 1) begin exp_stat = ADR; halted = 1'b1; return; end
      end
    end else begin
      junk(O_M);
    end
    junk(O_W);
    junk(O_P);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ric;
    bus.start = 1'b0; bus.icode = '0; bus.imem_error = 1'b0;
    bus.instr_valid = 1'b0; bus.mem_ready = 1'b0; bus.dmem_error = 1'b0;
    rst = 1'b1;
    mreq_seen = 0;
    done_seen = 0;

    // Reset state, then a three-instruction stream ending in halt.
    do_reset();
    step(O_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_start();
    run_instr(4'h3, 1'b0, 1'b1, -1, 1'b0);
    run_instr(4'h6, 1'b0, 1'b1, -1, 1'b0);
    run_instr(4'h0, 1'b0, 1'b1, -1, 1'b0);
    check("halt_stat", 32'(bus.stat), 32'd2);
    check("halt_instr_count", 32'(bus.instr_count), 32'd2);
    check("halt_cycle_count", 32'(bus.cycle_count), 32'd13);
    check("halt_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) junk(O_H);

    // mrmovq acked on the last allowed wait cycle, then pushq times out.
    do_reset();
    idle_start();
    mreq_seen = 0;
    done_seen = 0;
    run_instr(4'h5, 1'b0, 1'b1, 3, 1'b0);
    check("mrmovq_mem_req_cycles", 32'(mreq_seen), 32'd4);
    check("mrmovq_done_pulses", 32'(done_seen), 32'd1);
    check("mrmovq_cycle_count", 32'(bus.cycle_count), 32'd9);
    check("mrmovq_fetch_next", 32'(bus.fetch_en), 32'd1);
    mreq_seen = 0;
    run_instr(4'hA, 1'b0, 1'b1, -1, 1'b0);
    check("timeout_mem_req_cycles", 32'(mreq_seen), 32'd4);
    check("timeout_stat", 32'(bus.stat), 32'd3);
    check("timeout_instr_count", 32'(bus.instr_count), 32'd1);
    for (int i = 0; i < 2; i++) junk(O_H);

    // Fetch fault priority: ADR over INS, then INS alone.
    do_reset();
    idle_start();
    run_instr(4'h6, 1'b1, 1'b0, -1, 1'b0);
    check("fetch_adr_priority", 32'(bus.stat), 32'd3);
    junk(O_H);
    do_reset();
    idle_start();
    run_instr(4'h3, 1'b0, 1'b0, -1, 1'b0);
    check("fetch_ins", 32'(bus.stat), 32'd4);
    junk(O_H);

    // Reset during a pending memory wait while start is held high.
    do_reset();
    idle_start();
    step(O_F, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(O_D, 1'b1, rnd4(), rnd1(), rnd1(), 1'b0, rnd1(), 1'b0);
    step(O_E, 1'b1, rnd4(), rnd1(), rnd1(), 1'b0, rnd1(), 1'b0);
    step(O_MR, 1'b1, rnd4(), rnd1(), rnd1(), 1'b0, rnd1(), 1'b0);
    step(O_MR, 1'b1, rnd4(), rnd1(), rnd1(), 1'b0, rnd1(), 1'b1);
    step(O_IDLE, 1'b1, rnd4(), rnd1(), rnd1(), rnd1(), rnd1(), 1'b1);
    step(O_IDLE, 1'b1, rnd4(), rnd1(), rnd1(), rnd1(), rnd1(), 1'b0);
    run_instr(4'hA, 1'b0, 1'b1, 2, 1'b0);

    // Counter wrap with a 4-bit counter; start toggles randomly mid-run.
    do_reset();
    idle_start();
    run_instr(4'h6, 1'b0, 1'b1, -1, 1'b0);
    run_instr(4'h2, 1'b0, 1'b1, -1, 1'b0);
    run_instr(4'h7, 1'b0, 1'b1, -1, 1'b0);
    check("wrap_cycle_count", 32'(bus.cycle_count), 32'd2);
    check("wrap_instr_count", 32'(bus.instr_count), 32'd3);

    // Random instruction stream; restart after every halt.
    for (int n = 0; n < 60; n++) begin
      ric = rnd4();
      run_instr(ric, ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) != 0),
                $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
      if (halted) begin
        junk(O_H);
        do_reset();
        idle_start();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
